// File: rtl/wb_boot_copier.sv
// wb_boot_copier: Wishbone initiator that copies a boot image from flash to RAM, then releases the CPU.
// Optional WB_BOOT_COPIER_CHECKSUM_EN adds a checksum_o sum of words read, checked before completion.
module wb_boot_copier #(
    parameter logic [31:0] SRC_ADDRESS  = 32'h2000_0000,
    parameter logic [31:0] DST_ADDRESS  = 32'h1000_0000,
    parameter int          LENGTH_WORDS = 'h4000,
    parameter int          MAX_RETRIES  = 3
`ifdef WB_BOOT_COPIER_CHECKSUM_EN
    ,
    parameter logic [31:0] EXPECTED_CHECKSUM = 32'h0
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        error_o
`ifdef WB_BOOT_COPIER_CHECKSUM_EN
    ,
    output logic [31:0] checksum_o
`endif
);
    localparam int IW = LENGTH_WORDS > 0 ? $clog2(LENGTH_WORDS + 1) : 1;
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam logic [IW-1:0] LAST = IW'(LENGTH_WORDS);

    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, DONE, FAIL, CHK} state_t;

`ifdef WB_BOOT_COPIER_CHECKSUM_EN
    localparam state_t FIN = CHK;
`else
    localparam state_t FIN = DONE;
`endif

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [RW-1:0] rty_cnt, rty_cnt_n, rty_inc;
    logic [31:0]   data_q, data_n;
    logic          gap, gap_n;
    logic          busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            idx     <= '0;
            rty_cnt <= '0;
            data_q  <= '0;
            gap     <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            rty_cnt <= rty_cnt_n;
            data_q  <= data_n;
            gap     <= gap_n;
        end
    end

`ifdef WB_BOOT_COPIER_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            checksum_o <= '0;
        else if (state == RD_GAP)
            checksum_o <= checksum_o + data_q;
    end
`endif

    // gap marks the idle cycle between a retried attempt and its reissue
    always_comb begin
        busy      = (state == RD || state == WR) && !gap;
        state_n   = state;
        idx_n     = idx;
        rty_cnt_n = rty_cnt;
        data_n    = data_q;
        gap_n     = 1'b0;
        rty_inc   = rty_cnt + 1'b1;
        case (state)
            IDLE: state_n = (LENGTH_WORDS == 0) ? FIN : RD;
            RD, WR: begin
                if (busy) begin
                    if (err_i) begin
                        state_n = FAIL;
                    end else if (rty_i) begin
                        rty_cnt_n = rty_inc;
                        gap_n     = 1'b1;
                        state_n   = (rty_inc > RW'(MAX_RETRIES)) ? FAIL : state;
                    end else if (ack_i) begin
                        rty_cnt_n = '0;
                        data_n    = (state == RD) ? dat_i : data_q;
                        state_n   = (state == RD) ? RD_GAP : WR_GAP;
                    end
                end
            end
            RD_GAP: state_n = WR;
            WR_GAP: begin
                idx_n   = idx + 1'b1;
                state_n = (idx_n == LAST) ? FIN : RD;
            end
`ifdef WB_BOOT_COPIER_CHECKSUM_EN
            CHK: state_n = (checksum_o == EXPECTED_CHECKSUM) ? DONE : FAIL;
`endif
            default: ;
        endcase
    end

    assign cyc_o     = busy;
    assign stb_o     = busy;
    assign we_o      = busy && state == WR;
    assign sel_o     = busy ? 4'hF : 4'h0;
    assign adr_o     = busy ? ((state == WR) ? DST_ADDRESS : SRC_ADDRESS) + 32'({idx, 2'b00}) : 32'h0;
    assign dat_o     = data_q;
    assign cpu_rst_o = state != DONE;
    assign done_o    = state == DONE;
    assign error_o   = state == FAIL;
endmodule

// File: tb/tb_wb_boot_copier.sv
// tb_wb_boot_copier: randomized scoreboard bench with flash/RAM responders and a transfer-plan model.
module tb_wb_boot_copier;
    localparam logic [31:0] SRC = 32'h2000_0000;
    localparam logic [31:0] DST = 32'h1000_0000;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cyc_o, stb_o, we_o, ack_i, err_i, rty_i, cpu_rst_o, done_o, error_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;
    logic        cyc0, stb0, we0, cpu_rst0, done0, error0;
    logic [31:0] adr0, dat0;
    logic [3:0]  sel0;

    wb_boot_copier #(.SRC_ADDRESS(SRC), .DST_ADDRESS(DST), .LENGTH_WORDS(N), .MAX_RETRIES(3)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .sel_o(sel_o),
        .we_o(we_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
        .cpu_rst_o(cpu_rst_o), .done_o(done_o), .error_o(error_o));

    wb_boot_copier #(.SRC_ADDRESS(SRC), .DST_ADDRESS(DST), .LENGTH_WORDS(0), .MAX_RETRIES(3)) dut0 (
        .clk_i(clk), .rst_i(rst), .cyc_o(cyc0), .stb_o(stb0), .adr_o(adr0), .sel_o(sel0),
        .we_o(we0), .dat_o(dat0), .dat_i(32'h0), .ack_i(1'b0), .err_i(1'b0), .rty_i(1'b0),
        .cpu_rst_o(cpu_rst0), .done_o(done0), .error_o(error0));

    logic [31:0] flash [N];
    int          rd_wait [N];
    int          wr_rty [N];
    bit          err_first;
    logic [31:0] ram [N];
    int          wr_count, ws, rty_seen, w;
    logic [31:0] off;

    // Flash answers reads, RAM answers writes; faults are injected from the plan arrays
    always_comb begin
        off   = adr_o - (we_o ? DST : SRC);
        w     = int'(off[3:2]);
        dat_i = flash[w];
        err_i = stb_o && !we_o && err_first && off == 32'h0;
        rty_i = stb_o && we_o && !err_i && rty_seen < wr_rty[w];
        ack_i = stb_o && !err_i && !rty_i && (we_o || ws >= rd_wait[w]);
    end

    always @(posedge clk) begin
        if (rst) begin
            ws       <= 0;
            rty_seen <= 0;
            wr_count <= 0;
            for (int i = 0; i < N; i++) ram[i] <= 32'hDEAD_BEEF;
        end else begin
            ws <= (stb_o && !ack_i && !rty_i && !err_i) ? ws + 1 : 0;
            if (stb_o && rty_i) rty_seen <= rty_seen + 1;
            else if (stb_o && we_o && ack_i) rty_seen <= 0;
            if (stb_o && we_o && ack_i) begin
                ram[w]   <= dat_o;
                wr_count <= wr_count + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [68:0] exp_q[$];
    int          exp_cyc, exp_wr;
    bit          exp_fail;

    // Expected transfer list and completion time, derived word by word from the fault plan
    task automatic plan(input int limit);
        int c = 1;
        int k = 0;
        exp_fail = 0;
        exp_wr = 0;
        for (int i = 0; i < N; i++) begin
            if (k++ < limit) exp_q.push_back({4'hF, 1'b0, SRC + 32'(4 * i), 32'h0});
            if (err_first && i == 0) begin
                exp_fail = 1;
                c += 1;
                break;
            end
            c += 2 + rd_wait[i];
            for (int a = 0; a <= wr_rty[i] && a <= 3; a++)
                if (k++ < limit) exp_q.push_back({4'hF, 1'b1, DST + 32'(4 * i), flash[i]});
            if (wr_rty[i] > 3) begin
                exp_fail = 1;
                c += 7;
                break;
            end
            c += 2 + 2 * wr_rty[i];
            exp_wr++;
        end
        exp_cyc = c;
    endtask

    logic        hold, z_act;
    logic [32:0] hold_v;
    initial begin
        hold  = 1'b0;
        z_act = 1'b0;
    end

    always @(negedge clk) begin
        if (hold) chk("wait_stable", {stb_o, we_o, adr_o}, {1'b1, hold_v});
        hold   = stb_o && !ack_i && !rty_i && !err_i && !rst;
        hold_v = {we_o, adr_o};
        if (cyc0 || stb0) z_act = 1'b1;
        if (stb_o && (ack_i || rty_i || err_i)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL xfer: got we=%0d adr=%h, expected no transfer", we_o, adr_o);
            end else begin
                chk("xfer", {sel_o, we_o, adr_o, we_o ? dat_o : 32'h0}, exp_q.pop_front());
            end
        end
    end

    task automatic chk_reset(input string name);
        chk(name, {cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, cpu_rst_o, done_o, error_o},
            {3'b000, 4'h0, 32'h0, 32'h0, 3'b100});
    endtask

    task automatic run();
        int n = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("reset_values");
        chk("len0_reset", {cpu_rst0, done0}, 2'b10);
        rst = 1'b0;
        while (!(done_o || error_o) && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("len0_done", {cpu_rst0, done0, error0}, 3'b010);
            if (!done_o) chk("cpu_rst_held", cpu_rst_o, 1'b1);
        end
        chk("cycles", n, exp_cyc);
        chk("final", {done_o, error_o, cpu_rst_o}, exp_fail ? 3'b011 : 3'b100);
        chk("bus_idle", {cyc_o, stb_o, we_o, sel_o}, 7'h0);
        repeat (3) @(negedge clk);
        chk("terminal", {done_o, error_o, cyc_o}, exp_fail ? 3'b010 : 3'b100);
        chk("queue_empty", exp_q.size(), 0);
        chk("write_count", wr_count, exp_wr);
        for (int i = 0; i < N; i++) chk("ram", ram[i], i < exp_wr ? flash[i] : 32'hDEAD_BEEF);
        chk("len0_no_bus", z_act, 1'b0);
    endtask

    task automatic clear_faults();
        err_first = 0;
        for (int i = 0; i < N; i++) begin
            rd_wait[i] = 0;
            wr_rty[i]  = 0;
        end
    endtask

    initial begin
        int n;
        clear_faults();
        flash[0] = 32'h11; flash[1] = 32'h22; flash[2] = 32'h33; flash[3] = 32'h44;
        plan(1000); run();
        rd_wait[1] = 2;
        plan(1000); run();
        clear_faults(); wr_rty[2] = 3;
        plan(1000); run();
        wr_rty[2] = 4;
        plan(1000); run();
        clear_faults(); err_first = 1;
        plan(1000); run();
        clear_faults();
        for (int i = 0; i < N; i++) flash[i] = $urandom;
        plan(8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!(stb_o && we_o && adr_o == DST + 32'd12) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_w3", n < 100, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("mid_reset");
        chk("mid_reset_queue", exp_q.size(), 0);
        exp_q.delete();
        plan(1000); run();
        repeat (6) begin
            for (int i = 0; i < N; i++) begin
                flash[i]   = $urandom;
                rd_wait[i] = $urandom_range(0, 2);
                wr_rty[i]  = $urandom_range(0, 3);
            end
            plan(1000); run();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
